// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, parameter defaults and width helper
// for the UART transmit arbiter and its round-robin sub-block.
package uart_pkg;

    localparam int NUM_REQ_DEF      = 4;
    localparam int TIMEOUT_CLKS_DEF = 2048;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_t;

    // Width of an index/counter able to hold 0..n-1, never narrower than 1 bit.
    function automatic int ptr_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin pick. The search starts one
// past the last winner and wraps, so the previous owner has lowest priority.
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               valid,
    output logic [PTR_W-1:0]   winner,
    output logic [NUM_REQ-1:0] grant_oh
);

    // First pending request found walking forward from ptr+1.
    always_comb begin
        int idx;
        valid    = 1'b0;
        winner   = '0;
        grant_oh = '0;
        idx      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!valid && req[idx]) begin
                valid         = 1'b1;
                winner        = PTR_W'(idx);
                grant_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ requesters.
// A grant hands the winner's byte to the transmitter; i_Tx_Done closes the
// transaction. Defining UART_ARB_TIMEOUT_EN adds a WAIT watchdog of
// TIMEOUT_CLKS clocks that abandons a byte whose completion never arrives.
//
// state   | meaning
// ST_IDLE | nothing in flight; pending requests are arbitrated
// ST_WAIT | byte handed to transmitter; waiting for i_Tx_Done (or timeout)
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQ_DEF,
    parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic [NUM_REQ-1:0]   i_Req,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic [NUM_REQ-1:0]   o_Done,
    output logic                 o_Busy,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Done,
    output logic                 o_Timeout
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    arb_state_t         state, state_nxt;
    logic [PTR_W-1:0]   owner, owner_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [NUM_REQ-1:0] grant, grant_nxt;
    logic [NUM_REQ-1:0] done, done_nxt;
    logic               tx_dv, tx_dv_nxt;
    logic [7:0]         tx_byte, tx_byte_nxt;

    logic               arb_valid;
    logic [PTR_W-1:0]   arb_winner;
    logic [NUM_REQ-1:0] arb_grant_oh;

    logic               tx_done_ok;
    logic               tmo_hit;
    logic               expire;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req      (i_Req),
        .ptr      (ptr),
        .valid    (arb_valid),
        .winner   (arb_winner),
        .grant_oh (arb_grant_oh)
    );

    // The completion pulse is not trusted in the same cycle as the start
    // strobe, so a stale pulse from the previous byte cannot close this one.
    assign tx_done_ok = (state == ST_WAIT) && !tx_dv && i_Tx_Done;
    assign expire     = (state == ST_WAIT) && !tx_done_ok && tmo_hit;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int               TMR_W    = ptr_width(TIMEOUT_CLKS);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CLKS - 1);

    logic [TMR_W-1:0] tmr;
    logic             timeout;

    // Down-counter loaded at grant; terminal count at zero marks the
    // TIMEOUT_CLKS-th WAIT clock.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tmr <= '0;
        end else if (state == ST_IDLE) begin
            tmr <= arb_valid ? TMR_LOAD : '0;
        end else if (tmr != '0) begin
            tmr <= tmr - TMR_W'(1);
        end
    end

    assign tmo_hit = (tmr == '0);

    // One-cycle timeout pulse, registered like every other output.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            timeout <= 1'b0;
        end else begin
            timeout <= expire;
        end
    end

    assign o_Timeout = timeout;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CLKS;
    assign tmo_hit            = 1'b0;
    assign o_Timeout          = 1'b0;
`endif

    // State register and registered outputs. The pointer resets to the
    // last index so requester 0 is searched first after reset.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= ST_IDLE;
            owner   <= '0;
            ptr     <= PTR_W'(NUM_REQ - 1);
            grant   <= '0;
            done    <= '0;
            tx_dv   <= 1'b0;
            tx_byte <= 8'h00;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            ptr     <= ptr_nxt;
            grant   <= grant_nxt;
            done    <= done_nxt;
            tx_dv   <= tx_dv_nxt;
            tx_byte <= tx_byte_nxt;
        end
    end

    // Next-state and next-output decode; pulses default low every cycle.
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        ptr_nxt     = ptr;
        grant_nxt   = '0;
        done_nxt    = '0;
        tx_dv_nxt   = 1'b0;
        tx_byte_nxt = tx_byte;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_nxt   = arb_grant_oh;
                    tx_dv_nxt   = 1'b1;
                    tx_byte_nxt = i_Req_Byte[8*int'(arb_winner) +: 8];
                    owner_nxt   = arb_winner;
                    ptr_nxt     = arb_winner;
                    state_nxt   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tx_done_ok) begin
                    done_nxt[owner] = 1'b1;
                    state_nxt       = ST_IDLE;
                end else if (expire) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_Grant   = grant;
    assign o_Done    = done;
    assign o_Busy    = (state != ST_IDLE);
    assign o_Tx_DV   = tx_dv;
    assign o_Tx_Byte = tx_byte;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of arbitration vectors plus hand-written
// contention, fairness, reset-abort, dropped-request and timeout sequences,
// driving a behavioural UART transmitter (87 clocks per bit) and decoding
// its serial line.
module tb_uart_tx_arbiter;

    localparam int NREQ         = 4;
    localparam int CLKS_PER_BIT = 87;
    localparam int TOUT         = 2048;

    typedef struct {
        logic [NREQ-1:0]   req;
        logic [8*NREQ-1:0] bytes;
        logic [NREQ-1:0]   exp_grant;
        logic [7:0]        exp_byte;
    } vec_t;

    logic              i_Clock    = 1'b0;
    logic              i_Rst_n    = 1'b0;
    logic [NREQ-1:0]   i_Req      = '0;
    logic [8*NREQ-1:0] i_Req_Byte = '0;
    logic              i_Tx_Done;
    logic [NREQ-1:0]   o_Grant;
    logic [NREQ-1:0]   o_Done;
    logic              o_Busy;
    logic              o_Tx_DV;
    logic [7:0]        o_Tx_Byte;
    logic              o_Timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int td_cyc = -1000;

    uart_tx_arbiter #(
        .NUM_REQ      (NREQ),
        .TIMEOUT_CLKS (TOUT)
    ) dut (
        .i_Clock    (i_Clock),
        .i_Rst_n    (i_Rst_n),
        .i_Req      (i_Req),
        .i_Req_Byte (i_Req_Byte),
        .o_Grant    (o_Grant),
        .o_Done     (o_Done),
        .o_Busy     (o_Busy),
        .o_Tx_DV    (o_Tx_DV),
        .o_Tx_Byte  (o_Tx_Byte),
        .i_Tx_Done  (i_Tx_Done),
        .o_Timeout  (o_Timeout)
    );

    // 10 MHz clock: 100 time-unit period.
    always #50 i_Clock = ~i_Clock;

    always @(posedge i_Clock) cyc <= cyc + 1;

    // Behavioural transmitter: 8N1 frame, one-cycle done pulse after stop bit.
    logic       tx_busy   = 1'b0;
    logic [9:0] frame     = '1;
    int         bit_i     = 0;
    int         clk_i     = 0;
    logic       serial    = 1'b1;
    logic       tx_done_q = 1'b0;
    logic       tx_quiet  = 1'b0;

    always @(posedge i_Clock) begin
        tx_done_q <= 1'b0;
        if (!tx_busy) begin
            if (o_Tx_DV) begin
                tx_busy <= 1'b1;
                frame   <= {1'b1, o_Tx_Byte, 1'b0};
                bit_i   <= 0;
                clk_i   <= 0;
                serial  <= 1'b0;
            end
        end else if (clk_i == CLKS_PER_BIT - 1) begin
            clk_i <= 0;
            if (bit_i == 9) begin
                tx_busy   <= 1'b0;
                tx_done_q <= !tx_quiet;
            end else begin
                bit_i  <= bit_i + 1;
                serial <= frame[bit_i+1];
            end
        end else begin
            clk_i <= clk_i + 1;
        end
    end

    assign i_Tx_Done = tx_done_q;

    always @(negedge i_Clock) if (i_Tx_Done) td_cyc <= cyc;

    // Serial decoder sampling mid-bit.
    logic       rx_active = 1'b0;
    int         rx_clk    = 0;
    int         rx_bit    = 0;
    logic [7:0] rx_shift  = '0;
    logic [7:0] rx_byte   = '0;

    always @(posedge i_Clock) begin
        if (!rx_active) begin
            if (serial == 1'b0) begin
                rx_active <= 1'b1;
                rx_clk    <= 0;
                rx_bit    <= 0;
            end
        end else begin
            rx_clk <= rx_clk + 1;
            if (rx_clk == 43 + CLKS_PER_BIT * (rx_bit + 1)) begin
                if (rx_bit < 8) rx_shift <= {serial, rx_shift[7:1]};
                if (rx_bit == 7) rx_byte <= {serial, rx_shift[7:1]};
                if (rx_bit == 8) rx_active <= 1'b0;
                rx_bit <= rx_bit + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_Clock);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge i_Clock);
    endtask

    task automatic do_reset();
        i_Rst_n = 1'b0;
        ticks(2);
        i_Rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_grant(input int limit, output int gcyc);
        int n;
        n    = 0;
        gcyc = -1;
        while (o_Grant == '0 && n < limit) begin
            tick();
            n++;
        end
        if (o_Grant == '0) begin
            total++;
            bad++;
            $display("FAIL grant_wait: no o_Grant within %0d clocks", limit);
        end else begin
            gcyc = cyc;
        end
    endtask

    task automatic wait_done(input int limit, output int dcyc);
        int n;
        n    = 0;
        dcyc = -1;
        while (o_Done == '0 && n < limit) begin
            tick();
            n++;
        end
        if (o_Done == '0) begin
            total++;
            bad++;
            $display("FAIL done_wait: no o_Done within %0d clocks", limit);
        end else begin
            dcyc = cyc;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int dcyc;
        i_Req_Byte = v.bytes;
        i_Req      = v.req;
        tick();
        check($sformatf("%s_grant", tag), 32'(o_Grant), 32'(v.exp_grant));
        check($sformatf("%s_dv", tag), 32'(o_Tx_DV), 32'(1));
        check($sformatf("%s_byte", tag), 32'(o_Tx_Byte), 32'(v.exp_byte));
        i_Req = '0;
        tick();
        check($sformatf("%s_grant_pulse", tag), 32'(o_Grant), 32'(0));
        check($sformatf("%s_dv_pulse", tag), 32'(o_Tx_DV), 32'(0));
        check($sformatf("%s_busy", tag), 32'(o_Busy), 32'(1));
        wait_done(1200, dcyc);
        check($sformatf("%s_done", tag), 32'(o_Done), 32'(v.exp_grant));
        check($sformatf("%s_done_lat", tag), 32'(dcyc - td_cyc), 32'(1));
        check($sformatf("%s_idle", tag), 32'(o_Busy), 32'(0));
        check($sformatf("%s_byte_hold", tag), 32'(o_Tx_Byte), 32'(v.exp_byte));
        check($sformatf("%s_serial", tag), 32'(rx_byte), 32'(v.exp_byte));
        tick();
        check($sformatf("%s_done_pulse", tag), 32'(o_Done), 32'(0));
    endtask

    initial begin
        #(100 * 60000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        vec_t vr;
        int   fseq[4];
        int   gcyc, dcyc, prev, rel_cyc, n;
        logic flag;

        // Round-robin sequence from reset (pointer starts at 3).
        vecs[0] = '{4'b0100, 32'h00AB_0000, 4'b0100, 8'hAB};
        vecs[1] = '{4'b1011, 32'h5A00_C3E1, 4'b1000, 8'h5A};
        vecs[2] = '{4'b1001, 32'h7700_0096, 4'b0001, 8'h96};
        vecs[3] = '{4'b1001, 32'h3C00_00F0, 4'b1000, 8'h3C};
        vecs[4] = '{4'b0110, 32'h0042_1800, 4'b0010, 8'h18};
        vecs[5] = '{4'b0010, 32'h0000_6500, 4'b0010, 8'h65};
        vecs[6] = '{4'b1111, 32'hD4C3_B2A1, 4'b0100, 8'hC3};
        vecs[7] = '{4'b0011, 32'h0000_8E7F, 4'b0001, 8'h7F};
        fseq    = '{1, 3, 1, 3};

        ticks(2);
        check("rst_grant", 32'(o_Grant), 32'(0));
        check("rst_done", 32'(o_Done), 32'(0));
        check("rst_busy", 32'(o_Busy), 32'(0));
        check("rst_dv", 32'(o_Tx_DV), 32'(0));
        check("rst_byte", 32'(o_Tx_Byte), 32'(0));
        check("rst_timeout", 32'(o_Timeout), 32'(0));
        i_Rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Contention: all four pending after reset, each drops once granted.
        do_reset();
        i_Req_Byte = 32'h4433_2211;
        i_Req      = 4'b1111;
        prev       = -1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(1200, gcyc);
            check("cont_grant", 32'(o_Grant), 32'(1 << k));
            check("cont_byte", 32'(o_Tx_Byte), 32'(8'h11 * (k + 1)));
            if (k > 0) check("cont_gap", 32'(gcyc - prev), 32'(1));
            i_Req[k] = 1'b0;
            wait_done(1200, dcyc);
            check("cont_done", 32'(o_Done), 32'(1 << k));
            prev = dcyc;
        end
        tick();

        // Fairness: requesters 1 and 3 held high the whole time.
        do_reset();
        i_Req = 4'b1010;
        prev  = -1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(1200, gcyc);
            check("fair_grant", 32'(o_Grant), 32'(1 << fseq[k]));
            if (k > 0) check("fair_gap", 32'(gcyc - prev), 32'(1));
            wait_done(1200, dcyc);
            check("fair_done", 32'(o_Done), 32'(1 << fseq[k]));
            prev = dcyc;
            if (k == 3) i_Req = '0;
        end
        tick();

        // Reset 400 clocks into a byte: abort silently, ignore late done.
        do_reset();
        i_Req = 4'b0001;
        tick();
        check("abort_grant", 32'(o_Grant), 32'(1));
        i_Req = '0;
        ticks(399);
        i_Rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(o_Busy), 32'(0));
        check("abort_dv", 32'(o_Tx_DV), 32'(0));
        check("abort_byte", 32'(o_Tx_Byte), 32'(0));
        check("abort_done", 32'(o_Done), 32'(0));
        check("abort_grant0", 32'(o_Grant), 32'(0));
        check("abort_timeout", 32'(o_Timeout), 32'(0));
        ticks(2);
        i_Rst_n = 1'b1;
        rel_cyc = cyc;
        flag    = 1'b0;
        for (int k = 0; k < 700; k++) begin
            tick();
            if (o_Done != '0 || o_Busy) flag = 1'b1;
        end
        check("abort_no_done", 32'(flag), 32'(0));
        check("abort_late_txdone_seen", 32'(td_cyc > rel_cyc), 32'(1));
        vr = '{4'b0100, 32'h005C_0000, 4'b0100, 8'h5C};
        run_vec(vr, "after_abort");

        // Request pulsed for one cycle during WAIT is never served.
        i_Req_Byte = 32'h4433_2211;
        i_Req      = 4'b0001;
        tick();
        check("drop_grant", 32'(o_Grant), 32'(1));
        i_Req = '0;
        ticks(100);
        i_Req = 4'b0010;
        tick();
        i_Req = '0;
        wait_done(1200, dcyc);
        check("drop_done", 32'(o_Done), 32'(1));
        flag = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (o_Grant != '0) flag = 1'b1;
        end
        check("drop_never_granted", 32'(flag), 32'(0));

        // Transmitter never reports completion.
        tx_quiet = 1'b1;
        i_Req    = 4'b0010;
        tick();
        gcyc = cyc;
        check("tmo_grant", 32'(o_Grant), 32'(4'b0010));
        i_Req = '0;
`ifdef UART_ARB_TIMEOUT_EN
        n    = 0;
        flag = 1'b0;
        while (!o_Timeout && n < 2200) begin
            tick();
            n++;
            if (o_Done != '0) flag = 1'b1;
        end
        check("tmo_latency", 32'(cyc - gcyc), 32'(TOUT));
        check("tmo_no_done", 32'(flag), 32'(0));
        check("tmo_idle", 32'(o_Busy), 32'(0));
        tick();
        check("tmo_pulse", 32'(o_Timeout), 32'(0));
        vr = '{4'b0001, 32'h0000_00C9, 4'b0001, 8'hC9};
        tx_quiet = 1'b0;
        ticks(5);
        run_vec(vr, "after_tmo");
`else
        n    = 0;
        flag = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            n++;
            if (!o_Busy || o_Timeout || o_Done != '0) flag = 1'b1;
        end
        check("hang_stays_busy", 32'(flag), 32'(0));
        check("hang_busy_end", 32'(o_Busy), 32'(1));
        tx_quiet = 1'b0;
        do_reset();
        check("hang_reset_idle", 32'(o_Busy), 32'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
